// File: rtl/risc_v_mike_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one-at-a-time word fetches and buffers replies for decode.
// Optional RISC_V_MIKE_IFU_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and sets a sticky misalign_err.
module risc_v_mike_ifu #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        misalign_err,
   output logic [1:0]  dbg_state
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_FULL  = 2'd3;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_tag_pc;
   logic          r_outstanding;
   logic          r_discard;
   logic          r_halt;
   logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
   logic [31:0]   r_fifo_word [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic          w_push;
   logic          w_grant;
   logic [CW:0]   w_credit;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Handshakes: imem_req/imem_addr hold until imem_gnt; a word moves to decode when instr_valid & instr_ready.
   assign w_pop    = instr_valid & instr_ready;
   assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding} - {{CW{1'b0}}, w_pop};
   assign imem_req = rst & ~redirect_valid & ~r_halt & (~r_outstanding | imem_rvalid)
                     & (w_credit < {1'b0, DEPTH_C});
   assign w_grant  = imem_req & imem_gnt;
   assign w_push   = imem_rvalid & ~r_discard & ~redirect_valid;

   assign imem_addr    = r_fetch_pc;
   assign instr_valid  = (r_count != '0);
   assign instr        = r_fifo_word[r_rd_ptr];
   assign instr_pc     = r_fifo_pc[r_rd_ptr];
   assign misalign_err = r_halt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_tag_pc      <= '0;
         r_outstanding <= 1'b0;
         r_discard     <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_pc[i]   <= '0;
            r_fifo_word[i] <= '0;
         end
      end else if (redirect_valid) begin
         // The low PC bits are masked, so a misaligned target fetches its containing word.
         r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_discard  <= r_outstanding & ~imem_rvalid;
         if (imem_rvalid) r_outstanding <= 1'b0;
      end else begin
         if (w_grant) begin
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_tag_pc      <= r_fetch_pc;
            r_outstanding <= 1'b1;
         end else if (imem_rvalid) begin
            r_outstanding <= 1'b0;
         end
         if (imem_rvalid && r_discard) r_discard <= 1'b0;
         if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_tag_pc;
            r_fifo_word[r_wr_ptr] <= imem_rdata;
            r_wr_ptr              <= next_ptr(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

`ifdef RISC_V_MIKE_IFU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                             r_halt <= 1'b0;
      else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) r_halt <= 1'b1;
   end
`else
   assign r_halt = 1'b0;
`endif

   always_comb begin
      dbg_state = ST_FETCH;
      if (!rst)                                          dbg_state = ST_RESET;
      else if (r_count == DEPTH_C)                       dbg_state = ST_FULL;
      else if ((r_outstanding && !imem_req) || r_halt)   dbg_state = ST_WAIT;
   end

   // The credit term in imem_req reserves a slot for every outstanding word.
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(w_push && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_risc_v_mike_ifu.sv
// Directed bench for risc_v_mike_ifu: bench-side memory, per-cycle reference model and hand-computed checks.
// Honours RISC_V_MIKE_IFU_MISALIGN_TRAP_EN in the misaligned-redirect scenario.
module tb_risc_v_mike_ifu;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          FIFO_DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        misalign_err;
   logic [1:0]  dbg_state;

   risc_v_mike_ifu #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .misalign_err(misalign_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int lat   = 1;
   logic gnt_en = 1'b1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] g_addr[$];
   logic [31:0] g_cyc[$];
   logic [31:0] p_pc[$];
   logic [31:0] p_cyc[$];

   logic [31:0] m_pc;
   logic [31:0] m_tag;
   int          m_out;
   logic        m_disc;
   logic        m_err;
   logic        m_pop;
   logic        m_req;
   int          rc;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a ^ 32'hC3A5_0F1E) + {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hBAD0_0001;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      g_addr.delete();
      g_cyc.delete();
      p_pc.delete();
      p_cyc.delete();
   endtask

   // ---------------- driver: one call = one clock cycle, entered at a falling edge ----------------
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
      ent_t unused_e;
      redirect_valid = rv;
      redirect_pc    = rpc;
      instr_ready    = rdy;
      if (!rst) begin
         pend_addr.delete();
         pend_due.delete();
      end
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memword(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      imem_gnt = imem_req & gnt_en;
      if (imem_gnt) begin
         pend_addr.push_back(imem_addr);
         pend_due.push_back(cyc + lat);
         g_addr.push_back(imem_addr);
         g_cyc.push_back(32'(cyc));
      end
      unused_e.pc = 0;
      @(negedge clk);
      cyc++;
   endtask

   // ---------------- scoreboard: reference model checked every cycle ----------------
   always @(negedge clk) begin
      ent_t e;
      #2;
      if (!rst) begin
         chk("rst_req", imem_req, 1'b0);
         chk("rst_addr", imem_addr, RESET_PC);
         chk("rst_valid", instr_valid, 1'b0);
         chk("rst_instr", instr, 32'h0);
         chk("rst_instr_pc", instr_pc, 32'h0);
         chk("rst_misalign", misalign_err, 1'b0);
         chk("rst_dbg_state", 32'(dbg_state), 32'd0);
         exp_q.delete();
         m_pc   = RESET_PC;
         m_tag  = 32'h0;
         m_out  = 0;
         m_disc = 1'b0;
         m_err  = 1'b0;
      end else begin
         m_pop = (exp_q.size() != 0) && instr_ready;
         m_req = !redirect_valid && !m_err && (m_out == 0 || imem_rvalid)
                 && (exp_q.size() + m_out - (m_pop ? 1 : 0) < FIFO_DEPTH);
         chk("req", imem_req, m_req);
         if (m_req) chk("addr", imem_addr, m_pc);
         chk("valid", instr_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("instr_pc", instr_pc, exp_q[0].pc);
            chk("instr", instr, exp_q[0].word);
         end
         chk("misalign", misalign_err, m_err);
         if (instr_valid && instr_ready && !redirect_valid) begin
            p_pc.push_back(instr_pc);
            p_cyc.push_back(32'(cyc));
         end
         if (redirect_valid) begin
            exp_q.delete();
            if (imem_rvalid) begin
               m_disc = 1'b0;
               m_out  = 0;
            end else if (m_out != 0) begin
               m_disc = 1'b1;
            end
            m_pc = {redirect_pc[31:2], 2'b00};
`ifdef RISC_V_MIKE_IFU_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
`endif
         end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (imem_rvalid) begin
               if (m_disc) m_disc = 1'b0;
               else begin
                  e.pc   = m_tag;
                  e.word = memword(m_tag);
                  exp_q.push_back(e);
               end
            end
            if (m_req && imem_gnt) begin
               m_tag = m_pc;
               m_pc  = m_pc + 32'd4;
               m_out = 1;
            end else if (imem_rvalid) begin
               m_out = 0;
            end
         end
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin
      rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
      @(negedge clk);
      repeat (3) cycle(1'b0, 32'h0, 1'b1);
      chk("t0_req", imem_req, 1'b0);
      chk("t0_addr", imem_addr, 32'h0);

      // streaming from reset with a 1-cycle memory
      rst = 1'b1;
      clear_logs();
      repeat (8) cycle(1'b0, 32'h0, 1'b1);
      chk("t1_addr0", at(g_addr, 0), 32'h0);
      chk("t1_addr1", at(g_addr, 1), 32'h4);
      chk("t1_addr2", at(g_addr, 2), 32'h8);
      chk("t1_addr3", at(g_addr, 3), 32'hC);
      chk("t1_back2back", at(g_cyc, 3) - at(g_cyc, 0), 32'd3);
      chk("t1_latency", at(p_cyc, 0) - at(g_cyc, 0), 32'd2);
      chk("t1_pc0", at(p_pc, 0), 32'h0);
      chk("t1_pc2", at(p_pc, 2), 32'h8);

      // decoder stalls: buffer fills and requests stop
      clear_logs();
      repeat (10) cycle(1'b0, 32'h0, 1'b0);
      chk("t2_no_gnt", 32'(g_addr.size()), 32'd0);
      chk("t2_no_pop", 32'(p_pc.size()), 32'd0);
      chk("t2_req_low", imem_req, 1'b0);
      chk("t2_full_state", 32'(dbg_state), 32'd3);
      chk("t2_head", instr_pc, 32'h18);
      clear_logs();
      repeat (6) cycle(1'b0, 32'h0, 1'b1);
      chk("t2_pc0", at(p_pc, 0), 32'h18);
      chk("t2_pc1", at(p_pc, 1), 32'h1C);
      chk("t2_pc2", at(p_pc, 2), 32'h20);
      chk("t2_pc5", at(p_pc, 5), 32'h2C);
      chk("t2_gnt0", at(g_addr, 0), 32'h20);

      // grant withheld: request and address held until granted
      clear_logs();
      rc = cyc;
      gnt_en = 1'b0;
      repeat (3) cycle(1'b0, 32'h0, 1'b1);
      gnt_en = 1'b1;
      repeat (4) cycle(1'b0, 32'h0, 1'b1);
      chk("stall_gnt0", at(g_addr, 0), 32'h38);
      chk("stall_gnt_cyc", at(g_cyc, 0) - 32'(rc), 32'd3);
      chk("stall_pc2", at(p_pc, 2), 32'h38);

      // redirect with a slow response in flight: that word is discarded
      clear_logs();
      lat = 4;
      cycle(1'b1, 32'h20, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      lat = 1;
      rc = cyc;
      cycle(1'b1, 32'h100, 1'b1);
      repeat (8) cycle(1'b0, 32'h0, 1'b1);
      chk("t3_gnt0", at(g_addr, 0), 32'h20);
      chk("t3_gnt1", at(g_addr, 1), 32'h100);
      chk("t3_gnt1_cyc", at(g_cyc, 1) - 32'(rc), 32'd3);
      chk("t3_pc0", at(p_pc, 0), 32'h100);
      chk("t3_pc0_cyc", at(p_cyc, 0) - 32'(rc), 32'd5);

      // redirect together with rvalid and pop
      clear_logs();
      rc = cyc;
      cycle(1'b1, 32'h200, 1'b1);
      chk("t4_flush", instr_valid, 1'b0);
      repeat (5) cycle(1'b0, 32'h0, 1'b1);
      chk("t4_gnt0", at(g_addr, 0), 32'h200);
      chk("t4_gnt0_cyc", at(g_cyc, 0) - 32'(rc), 32'd1);
      chk("t4_pc0", at(p_pc, 0), 32'h200);
      chk("t4_pc0_cyc", at(p_cyc, 0) - 32'(rc), 32'd3);
      chk("t4_pc1", at(p_pc, 1), 32'h204);

      // PC wrap at the top of the address space
      clear_logs();
      cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (6) cycle(1'b0, 32'h0, 1'b1);
      chk("t5_gnt0", at(g_addr, 0), 32'hFFFF_FFF8);
      chk("t5_gnt1", at(g_addr, 1), 32'hFFFF_FFFC);
      chk("t5_gnt2", at(g_addr, 2), 32'h0000_0000);
      chk("t5_pc1", at(p_pc, 1), 32'hFFFF_FFFC);
      chk("t5_pc2", at(p_pc, 2), 32'h0000_0000);

      // misaligned redirect target
      clear_logs();
      cycle(1'b1, 32'h102, 1'b1);
      repeat (5) cycle(1'b0, 32'h0, 1'b1);
`ifdef RISC_V_MIKE_IFU_MISALIGN_TRAP_EN
      chk("t6_err", misalign_err, 1'b1);
      chk("t6_no_gnt", 32'(g_addr.size()), 32'd0);
      chk("t6_empty", instr_valid, 1'b0);
`else
      chk("t6_err", misalign_err, 1'b0);
      chk("t6_gnt0", at(g_addr, 0), 32'h100);
      chk("t6_pc0", at(p_pc, 0), 32'h100);
`endif

      // reset in the middle of operation
      rst = 1'b0;
      cycle(1'b0, 32'h0, 1'b1);
      chk("t7_req", imem_req, 1'b0);
      chk("t7_valid", instr_valid, 1'b0);
      chk("t7_addr", imem_addr, RESET_PC);
      chk("t7_err", misalign_err, 1'b0);
      rst = 1'b1;
      clear_logs();
      repeat (4) cycle(1'b0, 32'h0, 1'b1);
      chk("t7_gnt0", at(g_addr, 0), RESET_PC);
      chk("t7_pc0", at(p_pc, 0), RESET_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/risc_v_mike_ifu.md
# risc_v_mike_ifu

Instruction fetch unit feeding the control/decode stage of the RISC-V Mike core. Owns the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid interface, buffers returned words in a small FIFO, and presents them to the decoder with a valid/ready handshake. Handles redirects from branch/jump resolution, including discarding a response already in flight.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned)
- FIFO_DEPTH, 2, instruction buffer entries (≥2)
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request; held with imem_addr until imem_gnt
- imem_addr  output  32  word address of request (bits [1:0] always 0)
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid; at least 1 cycle after the matching gnt, in order
- imem_rdata  input  32  instruction word
- redirect_valid  input  1  load new fetch PC this cycle
- redirect_pc  input  32  redirect target
- instr_valid  output  1  instr/instr_pc hold a fetched instruction
- instr  output  32  instruction word to decoder
- instr_pc  output  32  address of instr
- instr_ready  input  1  decoder consumes instr this cycle
- misalign_err  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: fetch_pc, outstanding (0/1), discard flag, FIFO of {pc, word}, count.
- At most one request outstanding. pop = instr_valid & instr_ready.
- imem_req = ~redirect_valid & (outstanding==0 | imem_rvalid) & (count + outstanding − pop < FIFO_DEPTH). imem_addr = fetch_pc.
- On imem_req & imem_gnt: fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC → 0x0000_0000); outstanding ← 1, tagged with the granted PC.
- On imem_rvalid: outstanding cleared unless a new grant the same cycle. If discard=0, push {tag pc, imem_rdata}; if discard=1, drop word, clear discard.
- FIFO head drives instr/instr_pc; instr_valid = count≠0. Push and pop in the same cycle leave count unchanged. The credit rule guarantees no push when full; push on full is an assertion failure.
- Redirect (priority over everything): FIFO flushed (count←0; a same-cycle pop is ignored), fetch_pc ← redirect_pc[31:2],2'b00, no request that cycle. If a request is outstanding and its rvalid is not this cycle, discard←1. A same-cycle rvalid is dropped.
- States: RESET (rst low), FETCH (req eligible), WAIT (outstanding, req blocked by credit), FULL (count = FIFO_DEPTH). Transitions follow purely from the counters above; no extra state register required.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, fetch_pc RESET_PC, outstanding 0, discard 0, count 0, instr_valid 0, instr 0, instr_pc 0, misalign_err 0.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Latency: gnt in cycle N, rvalid in N+1 → instr_valid in N+2.
- Throughput: one instruction per cycle with 1-cycle memory and instr_ready held high.
- Redirect in cycle N: first request to the target issues in N+1; instr_valid is 0 from N+1 until the new data returns.
- Reset mid-operation: all state returns to reset values immediately. A memory response arriving after reset is a system-level error, not handled.

## Configuration
- RISC_V_MIKE_IFU_MISALIGN_TRAP_EN defined: redirect_pc[1:0]≠0 sets misalign_err (sticky until reset), and fetching halts with imem_req forced 0 until reset. FIFO is still flushed.
- Undefined: redirect_pc[1:0] silently cleared, and misalign_err tied 0.

## Test plan
- Reset release, 1-cycle memory, ready=1 → addresses 0x0,0x4,0x8… on consecutive cycles; first instr_valid 2 cycles after first gnt; instr_pc matches word.
- ready=0 for 10 cycles → exactly FIFO_DEPTH words buffered, imem_req low. Ready=1 → words delivered in order, no loss or duplicate.
- Redirect to 0x100 while request to 0x20 outstanding, rvalid 3 cycles later → 0x20 word dropped; next instr_pc=0x100.
- Redirect same cycle as rvalid and pop → FIFO empty next cycle; that word dropped; req to target next cycle.
- Redirect to 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Redirect to 0x102: with macro → misalign_err=1 and no further req. Without macro → fetch 0x100, misalign_err=0.
